// File: rtl/div_25.sv
// rtl/div_25.sv - fractional clock divider, o_clk = clk / (DIV_INT + 0.5)
// Uses both edges of clk: a posedge pulse and a negedge pulse alternate to form o_clk.
`timescale 1ns/1ps
module div_25 #(
  parameter int DIV_INT = 2,
  parameter int CNT_W   = 9
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_clk
);

  localparam logic [CNT_W-1:0] LP_WRAP = CNT_W'(2 * DIV_INT);
  localparam logic [CNT_W-1:0] LP_MID  = CNT_W'(DIV_INT);

  logic [CNT_W-1:0] r_cnt;
  logic             r_p;
  logic             r_n;

  // rst_n is active-high despite its name
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_cnt <= '0;
      r_p   <= 1'b0;
    end else begin
      r_cnt <= (r_cnt == LP_WRAP) ? '0 : r_cnt + CNT_W'(1);
      r_p   <= (r_cnt == LP_WRAP);
    end
  end

  // Half-cycle-offset pulse; reset is sampled on this edge too
  always_ff @(negedge clk) begin
    r_n <= (r_cnt == LP_MID) && !rst_n;
  end

  assign o_clk = r_p | r_n;

endmodule

// File: tb/tb_div_25.sv
// tb/tb_div_25.sv - self-checking bench for div_25 at ratios 1.5, 2.5 and 7.5
`timescale 1ns/1ps
module tb_div_25;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic o1, o2, o7;

  div_25 #(.DIV_INT(1)) u_div1 (.clk(clk), .rst_n(rst), .o_clk(o1));
  div_25 #(.DIV_INT(2)) u_div2 (.clk(clk), .rst_n(rst), .o_clk(o2));
  div_25 #(.DIV_INT(7)) u_div7 (.clk(clk), .rst_n(rst), .o_clk(o7));

  always #10 clk = ~clk;

  int  n_tests = 0;
  int  n_fail  = 0;
  bit  chk_en  = 1'b0;
  bit  running = 1'b0;
  time t_e1    = 0;

  typedef struct {
    int   off;
    logic e1;
    logic e2;
    logic e7;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t ns: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic wait_until(input time t);
    if (t > $time) #(t - $time);
  endtask

  // Stimulus tracker: time of the first posedge that sees reset released
  always @(posedge clk) begin
    if (rst) running <= 1'b0;
    else if (!running) begin
      running <= 1'b1;
      t_e1    <= $time;
    end
  end

  // Reference: rises at (N-0.5) clk after E1, then every (N+0.5) clk, high for 1 clk
  function automatic logic model(input int n, input time s);
    longint ph;
    if (!running) return 1'b0;
    ph = longint'(s) - longint'(t_e1) - longint'((2 * n - 1) * 10);
    if (ph < 0) return 1'b0;
    return (ph % longint'((2 * n + 1) * 10)) < 20;
  endfunction

  always @(posedge clk or negedge clk) begin
    #5;
    if (chk_en && !(rst && running)) begin
      check("rand_n1", o1, model(1, $time));
      check("rand_n2", o2, model(2, $time));
      check("rand_n7", o7, model(7, $time));
    end
  end

  initial begin
    time te1;
    int  hold;

    tbl[0]  = '{5,   1'b0, 1'b0, 1'b0};
    tbl[1]  = '{15,  1'b1, 1'b0, 1'b0};
    tbl[2]  = '{25,  1'b1, 1'b0, 1'b0};
    tbl[3]  = '{35,  1'b0, 1'b1, 1'b0};
    tbl[4]  = '{45,  1'b1, 1'b1, 1'b0};
    tbl[5]  = '{55,  1'b1, 1'b0, 1'b0};
    tbl[6]  = '{65,  1'b0, 1'b0, 1'b0};
    tbl[7]  = '{75,  1'b1, 1'b0, 1'b0};
    tbl[8]  = '{85,  1'b1, 1'b1, 1'b0};
    tbl[9]  = '{135, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{145, 1'b1, 1'b1, 1'b1};
    tbl[11] = '{155, 1'b0, 1'b0, 1'b0};

    te1 = 0;
    // Short reset, then a long one; output after release must match the table both times
    for (int pass = 0; pass < 2; pass++) begin
      @(posedge clk); #2;
      rst = 1'b1;
      for (int c = 0; c < ((pass == 0) ? 3 : 40); c++) begin
        @(posedge clk); #5;
        check("reset_n1", o1, 1'b0);
        check("reset_n2", o2, 1'b0);
        check("reset_n7", o7, 1'b0);
        #10;
        check("reset_neg_n2", o2, 1'b0);
      end
      @(posedge clk); #2;
      rst = 1'b0;
      te1 = $time + 18;
      for (int i = 0; i < 12; i++) begin
        wait_until(te1 + time'(tbl[i].off));
        check("start_n1", o1, tbl[i].e1);
        check("start_n2", o2, tbl[i].e2);
        check("start_n7", o7, tbl[i].e7);
      end
    end

    // Single-cycle reset while o_clk (N=2) is high from its negedge pulse
    wait_until(te1 + 242);
    rst = 1'b1;
    wait_until(te1 + 245); check("midrst_high", o2, 1'b1);
    wait_until(te1 + 255); check("midrst_fall", o2, 1'b0);
    wait_until(te1 + 262);
    rst = 1'b0;
    wait_until(te1 + 265); check("midrst_hold0", o2, 1'b0);
    wait_until(te1 + 285); check("restart_e1", o2, 1'b0);
    wait_until(te1 + 305); check("restart_pre", o2, 1'b0);
    wait_until(te1 + 315); check("restart_rise", o2, 1'b1);
    wait_until(te1 + 325); check("restart_high", o2, 1'b1);
    wait_until(te1 + 335); check("restart_low", o2, 1'b0);
    wait_until(te1 + 365); check("restart_rise2", o2, 1'b1);
    wait_until(te1 + 375); check("restart_n1", o1, model(1, $time));
    check("restart_n7", o7, model(7, $time));

    // Random reset pulses against the reference model
    @(posedge clk); #2;
    chk_en = 1'b1;
    hold   = 0;
    repeat (3000) begin
      @(posedge clk); #2;
      if (rst) begin
        hold--;
        if (hold <= 0) rst = 1'b0;
      end else if ($urandom_range(0, 99) < 3) begin
        rst  = 1'b1;
        hold = int'($urandom_range(1, 6));
      end
    end
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
